state_raising: RTL
==================

// Module: state_raising
// PURPOSE
//  Drawbridge raising controller: the opposite direction to the lowering FSM.
//  - Sequences a ship request through warning, deck-clear check, motor-up and
//    hold-raised phases, driving motor (MT), alarm (AL) and traffic light (TFL).
//  - Sits beside state_lowering in ponte-levadica and hands control to it via RAISED.
// PARAMETERS
//  WARN_CYCLES    8   cycles of alarm+red light before the deck-clear check (>=1)
//  RAISE_TIMEOUT  64  max RAISING cycles without S4 before FAULT (watchdog only)
// PORTS
//  Clock   in   1  single system clock, rising edge
//  Reset   in   1  asynchronous, active-low reset
//  S1      in   1  ship-request sensor (1 = ship waiting)
//  S2      in   1  vehicle-on-deck sensor (1 = occupied)
//  S3      in   1  bridge-down limit switch
//  S4      in   1  bridge-up limit switch
//  S5      in   1  emergency stop (1 = stop motor)
//  S6      in   1  road barrier closed confirmation
//  MT      out  1  motor-up command
//  AL      out  1  audible alarm
//  TFL     out  1  traffic light (0 = green, 1 = red)
//  RAISED  out  1  bridge held up; handshake to state_lowering
// BEHAVIOUR
//  - Clock/reset: one clock (Clock); Reset is asynchronous and active-low.
//  - Sensors are sampled on the rising edge of Clock.
//  - Outputs are Moore-decoded from the state register and change in the cycle
//    after the sampling edge. Input-to-output latency is 1 clock.
//  - Reset (Reset=0): state=IDLE, counter=0, MT=AL=TFL=RAISED=0.
//    Reset mid-RAISING stops the motor immediately (asynchronous).
//  - IDLE (MT0 AL0 TFL0): S1&S3 -> WARN, counter loads WARN_CYCLES-1.
//  - WARN (AL1 TFL1):
//    - S1=0 -> IDLE (abort).
//    - Otherwise counter decrements to 0 and holds. When counter==0 and S6=1 -> CLEAR.
//  - CLEAR (AL1 TFL1): wait for S2=0 -> RAISING, counter loads RAISE_TIMEOUT-1.
//    S1 is ignored from here on.
//  - RAISING (MT1 AL1 TFL1), priority order:
//    1. S4 -> UP. S4 wins over a simultaneous S5 or timeout.
//    2. S5 -> HALT.
//    3. Otherwise decrement the counter.
//  - HALT (MT0 AL1 TFL1): on S5=0 -> RAISING. Counter is frozen and not reloaded.
//  - UP (MT0 AL0 TFL1 RAISED1): stay until S3=1 (lowered by state_lowering) -> IDLE.
//  - S3&S4 both 1 in any state except IDLE -> FAULT (contradictory limits).
//  - FAULT (MT0 AL1 TFL1 RAISED0): absorbing; exit only via Reset.
//  - Counter width: $clog2(max(WARN_CYCLES,RAISE_TIMEOUT)+1). Counter saturates at 0, never wraps.
// CONFIGURATION
//  - RAISE_WATCHDOG_EN defined: RAISING with counter==0 and S4=0 -> FAULT.
//  - Undefined: no timeout; RAISING waits for S4 indefinitely. The counter is
//    still present for WARN; the FAULT transition from S3&S4 remains.
// STRUCTURE
//  - ponte_pkg: state encoding localparams (IDLE, WARN, CLEAR, RAISING, HALT,
//    UP, FAULT, 3-bit) and an output-decode table, shared with state_lowering.
//  - Sub-module cycle_timer: loadable saturating down-counter (load, en, zero
//    flag). Used by both WARN and the watchdog.
//  - Top: next-state logic, state register and output decode.
// TESTING  (bench: WARN_CYCLES=4, RAISE_TIMEOUT=16, watchdog defined)
//  1. Reset=0 with any sensors -> MT=AL=TFL=RAISED=0. Release -> IDLE holds with S1=0.
//  2. Nominal raise:
//     - S3=1,S1=1 -> AL=TFL=1 next cycle.
//     - S6=1 -> CLEAR after 4 WARN cycles. S2=0 -> MT=1.
//     - S4=1 -> MT=0, AL=0, RAISED=1, TFL=1.
//     - Then S3=1 -> IDLE with all outputs 0.
//  3. Abort: drop S1 during cycle 2 of WARN -> IDLE, AL=TFL=0. A vehicle
//     (S2=1) in CLEAR holds MT=0 until S2=0.
//  4. E-stop:
//     - S5=1 during RAISING -> MT=0, AL=1. Release -> MT=1 with the counter resumed.
//     - S4 and S5 in the same cycle -> UP.
//  5. Watchdog: RAISING 16 cycles without S4 -> FAULT (MT0 AL1 TFL1). S4 is then
//     ignored until Reset. Repeat without the macro -> no FAULT after 100 cycles.
//  6. S3=S4=1 in WARN -> FAULT.
//     Async Reset asserted mid-RAISING, between clock edges -> MT=0 immediately.

Source files
------------

// File: rtl/ponte_pkg.sv
// rtl/ponte_pkg.sv - drawbridge state encoding and lamp/motor decode table
package ponte_pkg;

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        WARN    = 3'd1,
        CLEAR   = 3'd2,
        RAISING = 3'd3,
        HALT    = 3'd4,
        UP      = 3'd5,
        FAULT   = 3'd6
    } state_t;

    typedef struct packed {
        logic mt;
        logic al;
        logic tfl;
        logic raised;
    } lamp_t;

    // Unused encodings decode like FAULT: alarm on, light red, motor off.
    function automatic lamp_t decode_outputs(input state_t s);
        lamp_t o;
        case (s)
            IDLE:    o = 4'b0000;
            WARN:    o = 4'b0110;
            CLEAR:   o = 4'b0110;
            RAISING: o = 4'b1110;
            HALT:    o = 4'b0110;
            UP:      o = 4'b0011;
            default: o = 4'b0110;
        endcase
        return o;
    endfunction

endpackage

// File: rtl/cycle_timer.sv
// rtl/cycle_timer.sv - loadable down-counter that saturates at zero
module cycle_timer #(
    parameter int W = 4
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         load,
    input  logic [W-1:0] load_value,
    input  logic         en,
    output logic         zero
);

    logic [W-1:0] cnt;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt <= '0;
        end else if (load) begin
            cnt <= load_value;
        end else if (en && (cnt != '0)) begin
            cnt <= cnt - 1'b1;
        end
    end

    assign zero = (cnt == '0);

endmodule

// File: rtl/state_raising.sv
// rtl/state_raising.sv - drawbridge raising sequencer; RAISE_WATCHDOG_EN adds the RAISING timeout
module state_raising
    import ponte_pkg::*;
#(
    parameter int WARN_CYCLES   = 8,
    parameter int RAISE_TIMEOUT = 64
) (
    input  logic Clock,
    input  logic Reset,
    input  logic S1,
    input  logic S2,
    input  logic S3,
    input  logic S4,
    input  logic S5,
    input  logic S6,
    output logic MT,
    output logic AL,
    output logic TFL,
    output logic RAISED
);

    localparam int CNT_MAX = (WARN_CYCLES > RAISE_TIMEOUT) ? WARN_CYCLES : RAISE_TIMEOUT;
    localparam int CW      = $clog2(CNT_MAX + 1);
    localparam logic [CW-1:0] WARN_LOAD  = CW'(WARN_CYCLES - 1);
    localparam logic [CW-1:0] RAISE_LOAD = CW'(RAISE_TIMEOUT - 1);

    state_t          state;
    state_t          state_nx;
    lamp_t           lamps;
    logic            tmr_load;
    logic            tmr_en;
    logic [CW-1:0]   tmr_value;
    logic            tmr_zero;

    cycle_timer #(.W(CW)) u_timer (
        .clk        (Clock),
        .rst_n      (Reset),
        .load       (tmr_load),
        .load_value (tmr_value),
        .en         (tmr_en),
        .zero       (tmr_zero)
    );

    always_comb begin
        state_nx  = state;
        tmr_load  = 1'b0;
        tmr_en    = 1'b0;
        tmr_value = WARN_LOAD;
        // Both limit switches closed means a broken sensor; trust neither.
        if ((state != IDLE) && S3 && S4) begin
            state_nx = FAULT;
        end else begin
            case (state)
                IDLE: if (S1 && S3) begin
                    state_nx = WARN;
                    tmr_load = 1'b1;
                end
                WARN: begin
                    if (!S1)                 state_nx = IDLE;
                    else if (tmr_zero && S6) state_nx = CLEAR;
                    else                     tmr_en   = 1'b1;
                end
                CLEAR: if (!S2) begin
                    state_nx  = RAISING;
                    tmr_load  = 1'b1;
                    tmr_value = RAISE_LOAD;
                end
                RAISING: begin
                    if (S4)            state_nx = UP;
`ifdef RAISE_WATCHDOG_EN
                    else if (tmr_zero) state_nx = FAULT;
`endif
                    else if (S5)       state_nx = HALT;
                    else               tmr_en   = 1'b1;
                end
                HALT:  if (!S5) state_nx = RAISING;
                UP:    if (S3)  state_nx = IDLE;
                FAULT: state_nx = FAULT;
                default: state_nx = FAULT;
            endcase
        end
    end

    always_ff @(posedge Clock or negedge Reset) begin
        if (!Reset) begin
            state <= IDLE;
            lamps <= '0;
        end else begin
            state <= state_nx;
            lamps <= decode_outputs(state_nx);
        end
    end

    assign MT     = lamps.mt;
    assign AL     = lamps.al;
    assign TFL    = lamps.tfl;
    assign RAISED = lamps.raised;

endmodule
